encoder_reader: RTL and testbench

ENCODER_READER -- requirements
Module: encoder_reader

---
 rtl/encoder_reader.sv | 136 +++++++++++++
 tb/tb_encoder_reader.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/encoder_reader.sv
// encoder_reader: quadrature encoder position counter with a memory-mapped
// control/status word. Optional per-channel glitch filter enabled by defining
// ENCODER_FILTER_EN (depth FILTER_LEN); default build uses synchronized inputs.
module encoder_reader #(
  parameter int COUNT_SIZE = 16,
  parameter int DATA_WIDTH = 32,
  parameter int FILTER_LEN = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enc_a,
  input  logic                  enc_b,
  input  logic [DATA_WIDTH-1:0] mem_in,
  output logic [DATA_WIDTH-1:0] mem_out,
  output logic                  step
);

`ifdef ENCODER_FILTER_EN
  localparam int PRIME_CYC = FILTER_LEN + 3;
`else
  localparam int PRIME_CYC = 3;
  localparam int unused_filter_len = FILTER_LEN;
`endif
  localparam int PW = $clog2(PRIME_CYC + 1);

  // pair layout: bit 1 = A, bit 0 = B
  logic [1:0] sync1, sync2, cur, prev;
  logic [PW-1:0] prime_cnt;
  logic primed;
  logic [COUNT_SIZE-1:0] pos;
  logic err, dir;

  logic clear, invert;
  logic [1:0] idx_c, idx_p, diff;
  logic fwd, rev, bad, up;

  assign clear  = mem_in[DATA_WIDTH-1];
  assign invert = mem_in[DATA_WIDTH-2];

  logic unused_mem_in;
  assign unused_mem_in = ^mem_in[DATA_WIDTH-3:0];

  // two-flop synchronizers for both channels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {enc_a, enc_b};
      sync2 <= sync1;
    end
  end

`ifdef ENCODER_FILTER_EN
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  logic [1:0][FW-1:0] flt_cnt;
  logic [1:0]         flt;

  // a channel adopts a new level only after FILTER_LEN identical samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flt_cnt <= '0;
      flt     <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == flt[i]) begin
          flt_cnt[i] <= '0;
        end else if (flt_cnt[i] == FW'(FILTER_LEN - 1)) begin
          flt[i]     <= sync2[i];
          flt_cnt[i] <= '0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + 1'b1;
        end
      end
    end
  end
  assign cur = flt;
`else
  assign cur = sync2;
`endif

  // Gray pair -> phase index: 00->0, 01->1, 11->2, 10->3; phase delta
  // of 1 is forward, 3 is reverse, 2 means both bits moved (illegal).
  always_comb begin
    idx_c = {cur[1], cur[1] ^ cur[0]};
    idx_p = {prev[1], prev[1] ^ prev[0]};
    diff  = idx_c - idx_p;
    fwd   = (diff == 2'd1);
    rev   = (diff == 2'd3);
    bad   = (diff == 2'd2);
    up    = fwd ^ invert;
  end

  // priming, edge decode, position/error/direction registers, step pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev      <= '0;
      prime_cnt <= '0;
      primed    <= 1'b0;
      pos       <= '0;
      err       <= 1'b0;
      dir       <= 1'b0;
      step      <= 1'b0;
    end else begin
      prev <= cur;
      step <= 1'b0;
      if (!primed) begin
        prime_cnt <= prime_cnt + 1'b1;
        if (prime_cnt == PW'(PRIME_CYC - 1)) primed <= 1'b1;
      end
      if (clear) begin
        // an edge arriving in the clear cycle is dropped for good
        pos <= '0;
        err <= 1'b0;
      end else if (primed) begin
        if (fwd || rev) begin
          pos  <= up ? pos + 1'b1 : pos - 1'b1;
          dir  <= up;
          step <= 1'b1;
        end else if (bad) begin
          err <= 1'b1;
        end
      end
    end
  end

  // status word straight from registers
  always_comb begin
    mem_out                   = '0;
    mem_out[COUNT_SIZE-1:0]   = pos;
    mem_out[DATA_WIDTH-1]     = err;
    mem_out[DATA_WIDTH-2]     = dir;
    mem_out[DATA_WIDTH-3]     = primed;
  end

endmodule

// File: tb/tb_encoder_reader.sv
// Directed bench for encoder_reader: reset, priming, forward/reverse counting,
// wrap, illegal jump, clear, inversion, glitch, clear priority, mid-run reset.
module tb_encoder_reader;

`ifdef ENCODER_FILTER_EN
  localparam int FLT = 3;
`else
  localparam int FLT = 0;
`endif
  localparam int LAT   = 3 + FLT;
  localparam int PRIME = 3 + FLT;
  localparam int HOLD  = 8 + FLT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enc_a = 1'b0, enc_b = 1'b0;
  logic [31:0] mem_in = '0;
  logic [31:0] mem_out;
  logic        step;

  int n_assert = 0;
  int n_fail   = 0;
  int step_cnt = 0;
  int s0;
  int ph = 0;
  logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  encoder_reader dut (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b),
    .mem_in(mem_in), .mem_out(mem_out), .step(step)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (step === 1'b1) step_cnt++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_pair(input logic [1:0] p);
    enc_a = p[1];
    enc_b = p[0];
  endtask

  // move n phases forward (d=1) or backward (d=-1), holding each level
  task automatic walk(input int n, input int d, input int hold);
    for (int i = 0; i < n; i++) begin
      ph = (ph + d + 4) % 4;
      set_pair(seq[ph]);
      tick(hold);
    end
  endtask

  task automatic do_clear();
    mem_in = 32'h8000_0000;
    tick(1);
    mem_in = '0;
    tick(1);
  endtask

  initial begin
    // reset state, no clock edge needed
    #1;
    chk("reset_mem_out", mem_out, 32'h0);
    chk("reset_step", {31'b0, step}, 32'h0);
    tick(2);
    rst = 1'b0;
    tick(PRIME - 1);
    chk("not_primed_yet", {31'b0, mem_out[29]}, 32'h0);
    tick(1);
    chk("primed", mem_out, 32'h2000_0000);

    // forward 4 steps, first one with latency checks
    s0 = step_cnt;
    ph = 1;
    set_pair(seq[1]);
    tick(LAT - 1);
    chk("latency_before", {16'b0, mem_out[15:0]}, 32'h0);
    tick(1);
    chk("latency_pos", {16'b0, mem_out[15:0]}, 32'h1);
    chk("latency_step", {31'b0, step}, 32'h1);
    tick(1);
    chk("step_one_cycle", {31'b0, step}, 32'h0);
    tick(HOLD - LAT - 1);
    walk(3, 1, HOLD);
    tick(LAT);
    chk("fwd4_word", mem_out, 32'h6000_0004);
    chk("fwd4_steps", step_cnt - s0, 32'd4);

    // reverse 4 from zero
    do_clear();
    chk("clear_to_zero", mem_out, 32'h6000_0000);
    walk(4, -1, HOLD);
    tick(LAT);
    chk("rev4_word", mem_out, 32'h2000_FFFC);

    // wrap: a full counter revolution returns to the same value
    s0 = step_cnt;
`ifdef ENCODER_FILTER_EN
    walk(16, 1, FLT + 1);
    tick(LAT + 2);
    chk("wrap_word", mem_out, 32'h6000_000C);
    chk("wrap_steps", step_cnt - s0, 32'd16);
`else
    walk(65536, 1, 1);
    tick(LAT + 2);
    chk("wrap_word", mem_out, 32'h6000_FFFC);
    chk("wrap_steps", step_cnt - s0, 32'd65536);
`endif

    // illegal double change 00 -> 11
    s0 = step_cnt;
    ph = 2;
    set_pair(seq[2]);
    tick(HOLD);
`ifdef ENCODER_FILTER_EN
    chk("jump_err", mem_out, 32'hE000_000C);
`else
    chk("jump_err", mem_out, 32'hE000_FFFC);
`endif
    chk("jump_no_step", step_cnt - s0, 32'd0);
    do_clear();
    chk("clear_err", mem_out, 32'h6000_0000);

    // inverted direction: two forward steps count down
    mem_in = 32'h4000_0000;
    walk(2, 1, HOLD);
    tick(LAT);
    chk("invert_word", mem_out, 32'h2000_FFFE);
    mem_in = '0;

    // 2-cycle glitch on A from 00
    do_clear();
    s0 = step_cnt;
    enc_a = 1'b1;
    tick(2);
    enc_a = 1'b0;
    tick(HOLD + 4);
    chk("glitch_pos", {16'b0, mem_out[15:0]}, 32'h0);
    chk("glitch_err", {31'b0, mem_out[31]}, 32'h0);
`ifdef ENCODER_FILTER_EN
    chk("glitch_steps", step_cnt - s0, 32'd0);
`else
    chk("glitch_steps", step_cnt - s0, 32'd2);
`endif

    // clear lands in the same cycle as a counted edge: edge is lost
    s0 = step_cnt;
    ph = 1;
    set_pair(seq[1]);
    tick(LAT - 1);
    mem_in = 32'h8000_0000;
    tick(1);
    mem_in = '0;
    tick(HOLD);
    chk("clear_prio_pos", {16'b0, mem_out[15:0]}, 32'h0);
    chk("clear_prio_steps", step_cnt - s0, 32'd0);

    // reset in the middle of a run
    walk(16, 1, FLT + 2);
    tick(LAT);
    chk("pre_rst_pos", {16'b0, mem_out[15:0]}, 32'h10);
    rst = 1'b1;
    #1;
    chk("rst_mid_mem_out", mem_out, 32'h0);
    chk("rst_mid_step", {31'b0, step}, 32'h0);
    tick(2);
    s0 = step_cnt;
    rst = 1'b0;
    walk(1, 1, PRIME + 4);
    chk("priming_edge_dropped", mem_out, 32'h2000_0000);
    chk("priming_no_step", step_cnt - s0, 32'd0);
    walk(1, 1, HOLD);
    chk("resume_count", mem_out, 32'h6000_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
